// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO, runtime data length / parity / stop-bit configuration.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst_L,
    input  logic [7:0]                  i_TX_Byte,
    input  logic                        i_TX_Valid,
    output logic                        o_TX_Ready,
    input  logic [3:0]                  i_Data_Bits,
    input  logic [1:0]                  i_Parity_Mode,
    input  logic                        i_Stop_Bits,
`ifdef UART_TX_BREAK_EN
    input  logic                        i_Break,
`endif
    output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count,
    output logic                        o_TX_Busy,
    output logic                        o_TX_Done,
    output logic                        o_TX_Serial
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = AW + 1;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
`ifdef UART_TX_BREAK_EN
        ,
        StBreak,
        StMark
`endif
    } state_e;

    // FIFO storage and pointers
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]   fifo_count;
    logic          fifo_empty, push, pop;
    logic [7:0]    head;

    assign fifo_count   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_TX_Ready   = (fifo_count != CntW'(FIFO_DEPTH));
    assign o_FIFO_Count = fifo_count;
    assign push         = i_TX_Valid && o_TX_Ready;
    assign head         = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_Clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_TX_Byte;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Frame configuration derived from the head entry at pop time
    logic [3:0] nbits_in;
    logic [7:0] mask_in;
    logic       par_in;

    always_comb begin
        if (i_Data_Bits < 4'd5) begin
            nbits_in = 4'd5;
        end else if (i_Data_Bits > 4'd8) begin
            nbits_in = 4'd8;
        end else begin
            nbits_in = i_Data_Bits;
        end
        case (nbits_in)
            4'd5:    mask_in = 8'h1F;
            4'd6:    mask_in = 8'h3F;
            4'd7:    mask_in = 8'h7F;
            default: mask_in = 8'hFF;
        endcase
        par_in = (^(head & mask_in)) ^ (i_Parity_Mode == 2'b10);
    end

    state_e        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    nbits_q, nbits_d;
    logic          par_en_q, par_en_d;
    logic          par_bit_q, par_bit_d;
    logic          stop2_q, stop2_d;
    logic          serial_q, serial_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end, bit_last, frame_boundary;

    assign bit_end  = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign bit_last = ({1'b0, bit_idx_q} == (nbits_q - 4'd1));

    always_comb begin
        state_d        = state_q;
        clk_cnt_d      = clk_cnt_q;
        bit_idx_d      = bit_idx_q;
        data_d         = data_q;
        nbits_d        = nbits_q;
        par_en_d       = par_en_q;
        par_bit_d      = par_bit_q;
        stop2_d        = stop2_q;
        serial_d       = serial_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        pop            = 1'b0;
        frame_boundary = 1'b0;

        case (state_q)
            StIdle: frame_boundary = 1'b1;
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    serial_d  = data_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_last) begin
                        bit_idx_d = '0;
                        if (par_en_q) begin
                            state_d  = StParity;
                            serial_d = par_bit_q;
                        end else begin
                            state_d  = StStop;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        serial_d  = data_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d   = StStop;
                    clk_cnt_d = '0;
                    serial_d  = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    // bit_idx marks the second stop bit when two are configured
                    if (stop2_q && (bit_idx_q == 3'd0)) begin
                        bit_idx_d = 3'd1;
                    end else begin
                        done_d         = 1'b1;
                        frame_boundary = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            StBreak: begin
                if (!i_Break) begin
                    state_d   = StMark;
                    clk_cnt_d = '0;
                    serial_d  = 1'b1;
                end
            end
            StMark: begin
                if (bit_end) begin
                    frame_boundary = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Idle decision point: shared by IDLE, end of frame and end of mark time
        if (frame_boundary) begin
            clk_cnt_d = '0;
            bit_idx_d = '0;
`ifdef UART_TX_BREAK_EN
            if (i_Break) begin
                state_d  = StBreak;
                serial_d = 1'b0;
                busy_d   = 1'b1;
            end else
`endif
            if (!fifo_empty) begin
                pop       = 1'b1;
                data_d    = head;
                nbits_d   = nbits_in;
                par_en_d  = (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
                par_bit_d = par_in;
                stop2_d   = i_Stop_Bits;
                state_d   = StStart;
                serial_d  = 1'b0;
                busy_d    = 1'b1;
            end else begin
                state_d  = StIdle;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            nbits_q   <= 4'd8;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            nbits_q   <= nbits_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_TX_Serial = serial_q;
    assign o_TX_Busy   = busy_q;
    assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushes queue per-clock expected line patterns,
// a negedge monitor pops and compares each frame as the DUT transmits it.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       i_Clk;
    logic       i_Rst_L;
    logic [7:0] i_TX_Byte;
    logic       i_TX_Valid;
    logic       o_TX_Ready;
    logic [3:0] i_Data_Bits;
    logic [1:0] i_Parity_Mode;
    logic       i_Stop_Bits;
`ifdef UART_TX_BREAK_EN
    logic       i_Break;
`endif
    logic [2:0] o_FIFO_Count;
    logic       o_TX_Busy;
    logic       o_TX_Done;
    logic       o_TX_Serial;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .i_TX_Byte     (i_TX_Byte),
        .i_TX_Valid    (i_TX_Valid),
        .o_TX_Ready    (o_TX_Ready),
        .i_Data_Bits   (i_Data_Bits),
        .i_Parity_Mode (i_Parity_Mode),
        .i_Stop_Bits   (i_Stop_Bits),
`ifdef UART_TX_BREAK_EN
        .i_Break       (i_Break),
`endif
        .o_FIFO_Count  (o_FIFO_Count),
        .o_TX_Busy     (o_TX_Busy),
        .o_TX_Done     (o_TX_Done),
        .o_TX_Serial   (o_TX_Serial)
    );

    typedef struct {
        logic [63:0] v;
        int          len;
    } frame_t;

    frame_t exp_q[$];
    int     gap_q[$];
    int     cnt_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     done_cnt = 0;
    int     cyc = 0;
    int     last_end = 0;
    bit     in_frame = 0;
    bit     mon_off = 0;

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line level for every clock of one frame, bit k = clock k
    function automatic frame_t build(input logic [7:0] b, input logic [3:0] db,
                                     input logic [1:0] pm, input logic sb);
        frame_t     f;
        logic [11:0] lv;
        int         nl;
        int         n;
        logic       p;
        n  = (db < 5) ? 5 : (db > 8) ? 8 : int'(db);
        lv = '0;
        lv[0] = 1'b0;
        nl = 1;
        p  = 1'b0;
        for (int i = 0; i < n; i++) begin
            lv[nl] = b[i];
            p      = p ^ b[i];
            nl++;
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            lv[nl] = p ^ (pm == 2'b10);
            nl++;
        end
        lv[nl] = 1'b1;
        nl++;
        if (sb) begin
            lv[nl] = 1'b1;
            nl++;
        end
        f.v   = '0;
        f.len = 0;
        for (int i = 0; i < nl; i++) begin
            for (int j = 0; j < CPB; j++) begin
                f.v[f.len] = lv[i];
                f.len++;
            end
        end
        return f;
    endfunction

    // Monitor: frame capture, gap and count recording, done pulse timing
    initial begin
        frame_t      cur;
        logic [63:0] obs;
        int          k;
        bit          pend_done;
        cur.v = '0;
        cur.len = 0;
        obs = '0;
        k = 0;
        pend_done = 0;
        forever begin
            @(negedge i_Clk);
            cyc++;
            if (o_TX_Done === 1'b1) done_cnt++;
            if (!i_Rst_L) begin
                in_frame  = 0;
                pend_done = 0;
                exp_q.delete();
            end else begin
                if (pend_done) begin
                    check_eq("done_pulse", o_TX_Done, 1);
                    pend_done = 0;
                end
                if (!mon_off && !in_frame && o_TX_Serial === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_start", o_TX_Serial, 1);
                    end else begin
                        cur      = exp_q.pop_front();
                        in_frame = 1;
                        obs      = '0;
                        k        = 0;
                        gap_q.push_back(cyc - last_end);
                        cnt_q.push_back(int'(o_FIFO_Count));
                    end
                end
                if (in_frame) begin
                    obs[k] = o_TX_Serial;
                    k++;
                    if (k == cur.len) begin
                        check_eq("frame", obs, cur.v);
                        check_eq("busy_in_frame", o_TX_Busy, 1);
                        in_frame  = 0;
                        pend_done = 1;
                        last_end  = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        while (!o_TX_Ready && n < 500) begin
            @(posedge i_Clk);
            #1;
            n++;
        end
        check_eq("push_ready", o_TX_Ready, 1);
        i_TX_Byte  = b;
        i_TX_Valid = 1'b1;
        exp_q.push_back(build(b, i_Data_Bits, i_Parity_Mode, i_Stop_Bits));
        @(posedge i_Clk);
        #1;
        i_TX_Valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame || o_TX_Busy) && n < 2000) begin
            @(posedge i_Clk);
            #1;
            n++;
        end
        check_eq("idle_reached", (n < 2000), 1);
        repeat (2) begin
            @(posedge i_Clk);
            #1;
        end
    endtask

    logic [7:0] t_byte [6] = '{8'hA5, 8'h35, 8'h35, 8'hFF, 8'h3C, 8'h96};
    logic [3:0] t_db   [6] = '{4'd8, 4'd7, 4'd7, 4'd2, 4'd12, 4'd6};
    logic [1:0] t_pm   [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10};
    logic       t_sb   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int         exp_cnt [5] = '{1, 3, 2, 1, 0};

    initial begin
        int d0;
        int lows;
        i_Rst_L       = 1'b0;
        i_TX_Byte     = 8'h00;
        i_TX_Valid    = 1'b0;
        i_Data_Bits   = 4'd8;
        i_Parity_Mode = 2'b00;
        i_Stop_Bits   = 1'b0;
`ifdef UART_TX_BREAK_EN
        i_Break       = 1'b0;
`endif
        repeat (2) @(posedge i_Clk);
        #1;
        check_eq("rst_serial", o_TX_Serial, 1);
        check_eq("rst_busy", o_TX_Busy, 0);
        check_eq("rst_done", o_TX_Done, 0);
        check_eq("rst_count", o_FIFO_Count, 0);
        check_eq("rst_ready", o_TX_Ready, 1);
        i_Rst_L = 1'b1;
        @(posedge i_Clk);
        #1;

        // Single frames with assorted configurations
        for (int i = 0; i < 6; i++) begin
            i_Data_Bits   = t_db[i];
            i_Parity_Mode = t_pm[i];
            i_Stop_Bits   = t_sb[i];
            d0 = done_cnt;
            push(t_byte[i]);
            if (i == 0) begin
                check_eq("line_idle_at_accept", o_TX_Serial, 1);
                @(posedge i_Clk);
                #1;
                check_eq("start_latency", o_TX_Serial, 0);
            end
            wait_idle();
            check_eq("done_count", done_cnt - d0, 1);
            check_eq("busy_after", o_TX_Busy, 0);
        end

        // Back-to-back frames from a full FIFO
        i_Data_Bits   = 4'd8;
        i_Parity_Mode = 2'b00;
        i_Stop_Bits   = 1'b0;
        gap_q.delete();
        cnt_q.delete();
        d0 = done_cnt;
        for (int i = 1; i <= 5; i++) push(8'(i));
        check_eq("b2b_count_full", o_FIFO_Count, 4);
        check_eq("b2b_ready_low", o_TX_Ready, 0);
        wait_idle();
        check_eq("b2b_frames", gap_q.size(), 5);
        check_eq("b2b_done", done_cnt - d0, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < gap_q.size()) begin
                if (i > 0) check_eq("b2b_gap", gap_q[i], 0);
                check_eq("b2b_count_at_start", cnt_q[i], exp_cnt[i]);
            end
        end

        // Reset during data bit 3
        push(8'h00);
        push(8'h00);
        repeat (18) @(posedge i_Clk);
        #1;
        check_eq("count_before_reset", o_FIFO_Count, 1);
        check_eq("line_low_before_reset", o_TX_Serial, 0);
        i_Rst_L = 1'b0;
        #1;
        check_eq("reset_serial", o_TX_Serial, 1);
        check_eq("reset_count", o_FIFO_Count, 0);
        check_eq("reset_busy", o_TX_Busy, 0);
        repeat (2) @(posedge i_Clk);
        #1;
        i_Rst_L = 1'b1;
        lows = 0;
        repeat (60) begin
            @(posedge i_Clk);
            #1;
            if (o_TX_Serial !== 1'b1) lows++;
        end
        check_eq("post_reset_idle", lows, 0);

`ifdef UART_TX_BREAK_EN
        begin
            int highs;
            mon_off = 1;
            d0 = done_cnt;
            i_Break = 1'b1;
            push(8'h55);
            lows = (o_TX_Serial === 1'b0) ? 1 : 0;
            repeat (19) begin
                @(posedge i_Clk);
                #1;
                if (o_TX_Serial === 1'b0) lows++;
            end
            check_eq("break_low", lows, 20);
            check_eq("break_busy", o_TX_Busy, 1);
            check_eq("break_count", o_FIFO_Count, 1);
            i_Break = 1'b0;
            highs = 0;
            repeat (4) begin
                @(posedge i_Clk);
                #1;
                if (o_TX_Serial === 1'b1) highs++;
            end
            check_eq("mark_high", highs, 4);
            mon_off = 0;
            @(posedge i_Clk);
            #1;
            check_eq("break_frame_start", o_TX_Serial, 0);
            wait_idle();
            check_eq("break_done", done_cnt - d0, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
